alu_issue_sequencer: RTL and testbench

//  Upstream issue stage for the mixed-precision ALU. Buffers operation requests
//  (opcode + half/single operands) in a DEPTH-entry FIFO and issues them one at a time.

---
 rtl/alu_issue_if.sv | 47 ++++
 rtl/alu_issue_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_issue_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Request, ALU operand/result and response signals shared by the issue sequencer
// and whatever drives it.
interface alu_issue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_opcode;
  logic [15:0]   in_a_half;
  logic [15:0]   in_b_half;
  logic [31:0]   in_a_single;
  logic [31:0]   in_b_single;

  logic [2:0]    alu_opcode;
  logic [15:0]   alu_a_half;
  logic [15:0]   alu_b_half;
  logic [31:0]   alu_a_single;
  logic [31:0]   alu_b_single;
  logic [15:0]   alu_result_half;
  logic [31:0]   alu_result_single;

  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_opcode;
  logic [15:0]   out_half;
  logic [31:0]   out_single;
  logic          out_divz;

  logic          busy;
  logic [CW-1:0] fifo_count;

  modport master (
    output in_valid, in_opcode, in_a_half, in_b_half, in_a_single, in_b_single,
    output alu_result_half, alu_result_single, out_ready,
    input  in_ready, alu_opcode, alu_a_half, alu_b_half, alu_a_single, alu_b_single,
    input  out_valid, out_opcode, out_half, out_single, out_divz, busy, fifo_count
  );

  modport slave (
    input  in_valid, in_opcode, in_a_half, in_b_half, in_a_single, in_b_single,
    input  alu_result_half, alu_result_single, out_ready,
    output in_ready, alu_opcode, alu_a_half, alu_b_half, alu_a_single, alu_b_single,
    output out_valid, out_opcode, out_half, out_single, out_divz, busy, fifo_count
  );
endinterface

// File: rtl/alu_issue_sequencer.sv
// Issue stage for the mixed-precision ALU: FIFO-buffers requests, holds operands for
// ALU_LAT cycles, then captures results into a valid/ready output register.
//
// state | meaning
// IDLE  | nothing in flight, waiting for a queued request
// WAIT  | operands on the ALU ports, counting down ALU_LAT
// RESP  | result captured, waiting for the consumer
module alu_issue_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [15:0] a_half;
    logic [15:0] b_half;
    logic [31:0] a_single;
    logic [31:0] b_single;
  } req_t;

  req_t          mem [DEPTH];
  req_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [TW-1:0] cnt;
  logic          push;
  logic          pop;
  logic          handshake;
  logic          divz_now;

  assign bus.in_ready   = (count != CW'(DEPTH));
  assign push           = bus.in_valid && bus.in_ready;
  assign handshake      = bus.out_valid && bus.out_ready;
  assign pop            = (count != '0) && ((state == IDLE) || ((state == RESP) && handshake));
  assign head           = mem[rd_ptr];
  assign bus.busy       = (state != IDLE) || (count != '0);
  assign bus.fifo_count = count;
  assign divz_now       = (bus.alu_opcode == 3'b011) &&
                          ((bus.alu_b_half == '0) || (bus.alu_b_single == '0));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{opcode: bus.in_opcode, a_half: bus.in_a_half, b_half: bus.in_b_half,
                       a_single: bus.in_a_single, b_single: bus.in_b_single};
    end
  end

  // Pointers are AW bits wide, so wrap mod DEPTH comes for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_opcode   <= '0;
      bus.alu_a_half   <= '0;
      bus.alu_b_half   <= '0;
      bus.alu_a_single <= '0;
      bus.alu_b_single <= '0;
    end else if (pop) begin
      bus.alu_opcode   <= head.opcode;
      bus.alu_a_half   <= head.a_half;
      bus.alu_b_half   <= head.b_half;
      bus.alu_a_single <= head.a_single;
      bus.alu_b_single <= head.b_single;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_opcode <= '0;
      bus.out_half   <= '0;
      bus.out_single <= '0;
      bus.out_divz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cnt   <= TW'(ALU_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            bus.out_opcode <= bus.alu_opcode;
            bus.out_half   <= bus.alu_result_half;
            bus.out_single <= bus.alu_result_single;
            bus.out_divz   <= divz_now;
            bus.out_valid  <= 1'b1;
            state          <= RESP;
          end
        end
        RESP: begin
          if (handshake) begin
            bus.out_valid <= 1'b0;
            if (pop) begin
              cnt   <= TW'(ALU_LAT - 1);
              state <= WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Scoreboard bench for alu_issue_sequencer with an adding ALU model.
module tb_alu_issue_sequencer;
  localparam int DEPTH   = 4;
  localparam int ALU_LAT = 2;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] h;
    logic [31:0] s;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   hs_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_issue_if #(.DEPTH(DEPTH)) bus();

  alu_issue_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.alu_result_half   = bus.alu_a_half + bus.alu_b_half;
  assign bus.alu_result_single = bus.alu_a_single + bus.alu_b_single;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got result op %0d half %0h, expected no result",
                 bus.out_opcode, bus.out_half);
      end else begin
        e = sb.pop_front();
        check("out_opcode", 64'(bus.out_opcode), 64'(e.op));
        check("out_half",   64'(bus.out_half),   64'(e.h));
        check("out_single", 64'(bus.out_single), 64'(e.s));
        check("out_divz",   64'(bus.out_divz),   64'(e.dz));
        hs_cyc.push_back(cyc);
      end
    end
  end

  task automatic push_op(input logic [2:0] op, input logic [15:0] ah, input logic [15:0] bh,
                         input logic [31:0] as_v, input logic [31:0] bs_v);
    exp_t e;
    int   waited = 0;
    bit   done = 0;
    bus.in_valid    = 1'b1;
    bus.in_opcode   = op;
    bus.in_a_half   = ah;
    bus.in_b_half   = bh;
    bus.in_a_single = as_v;
    bus.in_b_single = bs_v;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        e.op = op;
        e.h  = ah + bh;
        e.s  = as_v + bs_v;
        e.dz = (op == 3'b011) && ((bh == 16'd0) || (bs_v == 32'd0));
        sb.push_back(e);
        done = 1;
      end else if (++waited > 50) begin
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int  waited = 0;
    bit  done = 0;
    while (!done) begin
      @(negedge clk);
      if (!bus.busy && !bus.out_valid) begin
        done = 1;
      end else if (++waited > 300) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_timeout: got busy=%0d out_valid=%0d, expected idle", name,
                 bus.busy, bus.out_valid);
        done = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_opcode   = '0;
    bus.in_a_half   = '0;
    bus.in_b_half   = '0;
    bus.in_a_single = '0;
    bus.in_b_single = '0;
    bus.out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_in_ready",   64'(bus.in_ready),   64'd1);
    check("rst_fifo_count", 64'(bus.fifo_count), 64'd0);
    check("rst_out_valid",  64'(bus.out_valid),  64'd0);
    check("rst_busy",       64'(bus.busy),       64'd0);
    check("rst_alu_opcode", 64'(bus.alu_opcode), 64'd0);
    check("rst_out_single", 64'(bus.out_single), 64'd0);

    // Basic latency: out_valid rises exactly ALU_LAT+1 edges after the push edge.
    bus.out_ready = 1'b1;
    push_op(3'b000, 16'd3, 16'd4, 32'd10, 32'd20);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_out_valid_e%0d", k), 64'(bus.out_valid), (k == 3) ? 64'd1 : 64'd0);
    end
    check("t1_out_half",   64'(bus.out_half),   64'd7);
    check("t1_out_single", 64'(bus.out_single), 64'd30);
    check("t1_out_divz",   64'(bus.out_divz),   64'd0);
    wait_idle("t1");

    // Fill: first op goes in flight, the next four fill the FIFO.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      push_op(3'(i), 16'(100 * i), 16'(i), 32'(1000 * i), 32'(7 * i));
    check("full_fifo_count", 64'(bus.fifo_count), 64'd4);
    check("full_in_ready",   64'(bus.in_ready),   64'd0);
    bus.in_valid    = 1'b1;
    bus.in_opcode   = 3'd6;
    bus.in_a_half   = 16'hdead;
    bus.in_b_half   = 16'h0001;
    bus.in_a_single = 32'h1;
    bus.in_b_single = 32'h1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("full_no_accept", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("pp_in_ready",  64'(bus.in_ready),   64'd0);
    check("pp_out_valid", 64'(bus.out_valid),  64'd1);
    check("pp_count_pre", 64'(bus.fifo_count), 64'd4);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    check("pp_count_post", 64'(bus.fifo_count), 64'd3);
    wait_idle("t2");

    // Streaming throughput with wrap-around.
    hs_cyc.delete();
    for (int i = 0; i < 8; i++)
      push_op(3'(i), 16'(16'h0101 * i), 16'(i + 1), 32'(32'h10000 * i), 32'(3 * i));
    wait_idle("t3");
    check("stream_results", 64'(hs_cyc.size()), 64'd8);
    for (int i = 1; i < 8 && i < hs_cyc.size(); i++)
      check($sformatf("stream_gap_%0d", i), 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);

    // Divide-by-zero flag.
    push_op(3'b011, 16'd5, 16'd7, 32'd100, 32'd0);
    push_op(3'b011, 16'd1, 16'd1, 32'd1, 32'd1);
    push_op(3'b011, 16'd2, 16'd0, 32'd5, 32'd5);
    push_op(3'b010, 16'd2, 16'd0, 32'd5, 32'd0);
    wait_idle("t4");

    // Reset while WAIT with two queued.
    bus.out_ready = 1'b0;
    push_op(3'd1, 16'd1, 16'd2, 32'd3, 32'd4);
    push_op(3'd2, 16'd5, 16'd6, 32'd7, 32'd8);
    push_op(3'd3, 16'd9, 16'd9, 32'd9, 32'd9);
    check("pre_rst_count",     64'(bus.fifo_count), 64'd2);
    check("pre_rst_out_valid", 64'(bus.out_valid),  64'd0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_out_valid", 64'(bus.out_valid),  64'd0);
    check("mid_rst_count",     64'(bus.fifo_count), 64'd0);
    check("mid_rst_busy",      64'(bus.busy),       64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready),   64'd1);
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_quiet", 64'(bus.out_valid), 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
